// File: rtl/msk_rcon_seq.sv
// msk_rcon_seq -- masked AES key-schedule round-constant sequencer.
//
// Walks the AES round constants for one key expansion.
// The forward order is 01, 02, 04, ... and the inverse order runs the
// same list backwards from the last constant. The current constant is
// presented as a d-share Boolean sharing with a constant (non-random)
// share split.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a sequence (sampled in IDLE only)
//   mode[1:0]  key size at start: 00=128, 01=192, 10=256, 11=invalid
//   inverse    at start: 1 = decryption (reverse) order
//   step       advance to the next constant (sampled in RUN only)
//   abort      synchronous return to IDLE, highest priority
//   mask_rcon  forces sh_rcon to zero when low
//   busy       high while in RUN
//   last       high in RUN while the current constant is the final one
//   done       one-cycle pulse after the final step is accepted
//   err        one-cycle pulse after a start with an invalid mode
//   rcon_idx   number of steps accepted in the current sequence
//   sh_rcon    shared constant, bit b of share s at index d*b+s
module msk_rcon_seq #(
  parameter int d      = 2,
  parameter bit EN_192 = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic           inverse,
  input  logic           step,
  input  logic           abort,
  input  logic           mask_rcon,
  output logic           busy,
  output logic           last,
  output logic           done,
  output logic           err,
  output logic [3:0]     rcon_idx,
  output logic [8*d-1:0] sh_rcon
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] rcon_q;
  logic [3:0] idx_q;
  logic [1:0] mode_q;
  logic       inv_q;
  logic       done_q;
  logic       err_q;

  logic       mode_ok;
  logic [7:0] rcon_init_d;
  logic [7:0] rcon_adv_d;
  logic [3:0] last_idx;
  logic       share_en;

  // 192-bit mode can be compiled out; 2'b11 is never a key size.
  assign mode_ok = (mode != 2'b11) && (EN_192 || (mode != 2'b01));

  // Inverse order starts from the final forward constant of each key size.
  always_comb begin
    rcon_init_d = 8'h01;
    if (inverse) begin
      case (mode)
        2'b00:   rcon_init_d = 8'h36;
        2'b01:   rcon_init_d = 8'h80;
        default: rcon_init_d = 8'h40;
      endcase
    end
  end

  // Forward: multiply by x in GF(2^8). Inverse: divide by x, where 0x8d is
  // the reduction polynomial 0x11b shifted right by one.
  assign rcon_adv_d = inv_q ?
      ({1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00)) :
      ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00));

  // Index of the final constant (N-1) for the latched key size.
  always_comb begin
    case (mode_q)
      2'b00:   last_idx = 4'd9;
      2'b01:   last_idx = 4'd7;
      default: last_idx = 4'd6;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcon_q  <= 8'h01;
      idx_q   <= 4'd0;
      mode_q  <= 2'b00;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        rcon_q  <= 8'h01;
        idx_q   <= 4'd0;
      end else if (state_q == S_IDLE) begin
        if (start) begin
          if (mode_ok) begin
            state_q <= S_RUN;
            mode_q  <= mode;
            inv_q   <= inverse;
            rcon_q  <= rcon_init_d;
            idx_q   <= 4'd0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (step) begin
        if (idx_q == last_idx) begin
          state_q <= S_IDLE;
          rcon_q  <= 8'h01;
          idx_q   <= 4'd0;
          done_q  <= 1'b1;
        end else begin
          rcon_q <= rcon_adv_d;
          idx_q  <= idx_q + 4'd1;
        end
      end
    end
  end

  assign busy     = (state_q == S_RUN);
  assign last     = busy && (idx_q == last_idx);
  assign done     = done_q;
  assign err      = err_q;
  assign rcon_idx = idx_q;
  assign share_en = mask_rcon && busy;

  // The constant is public, so share 0 carries it and the others are zero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      for (genvar gj = 0; gj < d; gj++) begin : g_share
        if (gj == 0) begin : g_s0
          assign sh_rcon[d*gi+gj] = rcon_q[gi] & share_en;
        end else begin : g_sn
          assign sh_rcon[d*gi+gj] = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_msk_rcon_seq.sv
// Bench for msk_rcon_seq: two instances (d=2 with 192-bit mode, d=3
// without) share one stimulus stream and are compared every cycle with a
// reference model built on the AES round-constant list.
module tb_msk_rcon_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, inverse, step, abort, mask_rcon;
  logic [1:0] mode;

  logic        busy_a, last_a, done_a, err_a;
  logic [3:0]  idx_a;
  logic [15:0] sh_a;
  logic        busy_b, last_b, done_b, err_b;
  logic [3:0]  idx_b;
  logic [23:0] sh_b;

  msk_rcon_seq #(.d(2), .EN_192(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inverse(inverse),
    .step(step), .abort(abort), .mask_rcon(mask_rcon),
    .busy(busy_a), .last(last_a), .done(done_a), .err(err_a),
    .rcon_idx(idx_a), .sh_rcon(sh_a)
  );

  msk_rcon_seq #(.d(3), .EN_192(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inverse(inverse),
    .step(step), .abort(abort), .mask_rcon(mask_rcon),
    .busy(busy_b), .last(last_b), .done(done_b), .err(err_b),
    .rcon_idx(idx_b), .sh_rcon(sh_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // AES round constants in forward order.
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Reference model state, one entry per instance.
  bit m_busy [2];
  int m_k    [2];
  int m_n    [2];
  bit m_inv  [2];
  bit m_done [2];
  bit m_err  [2];
  bit m_en   [2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seq_len(input logic [1:0] m);
    case (m)
      2'b00:   return 10;
      2'b01:   return 8;
      default: return 7;
    endcase
  endfunction

  function automatic logic [23:0] exp_sh(input int dd, input logic [7:0] v);
    logic [23:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[dd*b] = v[b];
    return r;
  endfunction

  task automatic model_update();
    for (int j = 0; j < 2; j++) begin
      m_done[j] = 1'b0;
      m_err[j]  = 1'b0;
      if (rst || abort) begin
        m_busy[j] = 1'b0;
        m_k[j]    = 0;
      end else if (!m_busy[j]) begin
        if (start) begin
          if (mode == 2'b11 || (mode == 2'b01 && !m_en[j])) begin
            m_err[j] = 1'b1;
          end else begin
            m_busy[j] = 1'b1;
            m_k[j]    = 0;
            m_n[j]    = seq_len(mode);
            m_inv[j]  = inverse;
            if (j == 0) $display("start mode=%0d inv=%0d", mode, inverse);
          end
        end
      end else if (step) begin
        if (m_k[j] == m_n[j] - 1) begin
          m_busy[j] = 1'b0;
          m_k[j]    = 0;
          m_done[j] = 1'b1;
          if (j == 0) $display("sequence complete");
        end else begin
          m_k[j]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0]  rc;
    logic        e_last;
    logic [23:0] got_sh;
    for (int j = 0; j < 2; j++) begin
      rc = 8'h00;
      if (m_busy[j] && mask_rcon)
        rc = m_inv[j] ? rc_tab[m_n[j]-1-m_k[j]] : rc_tab[m_k[j]];
      e_last = m_busy[j] && (m_k[j] == m_n[j] - 1);
      got_sh = (j == 0) ? {8'h00, sh_a} : sh_b;
      chk($sformatf("busy%0d", j), (j == 0) ? busy_a : busy_b, m_busy[j]);
      chk($sformatf("last%0d", j), (j == 0) ? last_a : last_b, e_last);
      chk($sformatf("done%0d", j), (j == 0) ? done_a : done_b, m_done[j]);
      chk($sformatf("err%0d", j),  (j == 0) ? err_a  : err_b,  m_err[j]);
      chk($sformatf("idx%0d", j),  (j == 0) ? idx_a  : idx_b,  m_k[j]);
      chk($sformatf("sh%0d", j), got_sh, exp_sh(j == 0 ? 2 : 3, rc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input bit st, input logic [1:0] md, input bit inv,
                       input bit stp, input bit ab, input bit msk);
    start = st; mode = md; inverse = inv; step = stp; abort = ab; mask_rcon = msk;
    tick();
    start = 1'b0; step = 1'b0; abort = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_sh_a", sh_a, 16'h0);
    chk("rst_idx_a", idx_a, 4'd0);
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 1'b0; m_k[j] = 0; m_done[j] = 1'b0; m_err[j] = 1'b0;
    end
    tick();
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; mode = 0; inverse = 0; step = 0; abort = 0; mask_rcon = 1;
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 0; m_k[j] = 0; m_n[j] = 10; m_inv[j] = 0; m_done[j] = 0; m_err[j] = 0;
    end
    tick();
    tick();
    #2 rst = 1'b0;

    // 128 forward, ten steps, then observe done.
    drive(1, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 2'b00, 0, 1, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 1);

    // 192 inverse (rejected by the instance without 192 support).
    drive(1, 2'b01, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(0, 2'b00, 0, 1, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 1);

    // 256 inverse with mask toggling.
    drive(1, 2'b10, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) drive(0, 2'b00, 0, 1, 0, i[0]);
    drive(0, 2'b00, 0, 0, 0, 1);

    // Invalid mode, then start ignored while running.
    drive(1, 2'b11, 0, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 1);
    drive(1, 2'b00, 0, 0, 0, 1);
    drive(1, 2'b11, 1, 0, 0, 1);
    drive(0, 2'b00, 0, 1, 0, 1);

    // Abort together with step at index 4.
    drive(0, 2'b00, 0, 0, 1, 1);
    drive(1, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 2'b00, 0, 1, 0, 1);
    drive(1, 2'b00, 0, 1, 1, 1);
    drive(0, 2'b00, 0, 0, 0, 1);

    // Asynchronous reset mid-run, then a normal restart.
    drive(1, 2'b10, 0, 0, 0, 1);
    drive(0, 2'b00, 0, 1, 0, 1);
    drive(0, 2'b00, 0, 1, 0, 1);
    async_reset();
    drive(1, 2'b10, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) drive(0, 2'b00, 0, 1, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) == 0, 2'($urandom % 4), 1'($urandom % 2),
            ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 5) != 0);
      if (($urandom % 300) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msk_rcon_seq.md
MSK_RCON_SEQ -- requirements
Module: msk_rcon_seq

Interface
REQ-001 SHALL have parameter d, default 2, number of shares (d >= 2).
REQ-002 SHALL have parameter EN_192, default 1, enable AES-192 mode; if 0, mode 2'b01 is invalid.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin sequence; sampled in IDLE only.
REQ-006 SHALL have port mode, input, 2, key size at start: 00=128, 01=192, 10=256, 11=invalid.
REQ-007 SHALL have port inverse, input, 1, at start: 1 = reverse (decryption) order.
REQ-008 SHALL have port step, input, 1, advance to next round constant; sampled in RUN only.
REQ-009 SHALL have port abort, input, 1, synchronous return to IDLE.
REQ-010 SHALL have port mask_rcon, input, 1, gates sh_rcon to zero when low.
REQ-011 SHALL have port busy, output, 1, high in RUN.
REQ-012 SHALL have port last, output, 1, high in RUN while the current constant is the final one.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the final step is accepted.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a rejected start.
REQ-015 SHALL have port rcon_idx, output, 4, count of steps accepted in the current sequence.
REQ-016 SHALL have port sh_rcon, output, 8*d, shared round constant.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and RUN.
REQ-018 SHALL set sequence length N: 10 for 128, 8 for 192, 7 for 256.
REQ-019 SHALL, on start in IDLE with a valid mode, latch mode and inverse, load rcon, clear rcon_idx and enter RUN on the next cycle.
REQ-020 SHALL load rcon as 0x01 (forward), or 0x36/0x80/0x40 for inverse 128/192/256.
REQ-021 SHALL, on start in IDLE with an invalid mode, stay in IDLE, leave state unchanged and pulse err next cycle.
REQ-022 SHALL update rcon forward by xtime: shift left 1, XOR 0x1b if old bit7 was set.
REQ-023 SHALL update rcon inverse by division by x: shift right 1, XOR 0x8d if old bit0 was set.
REQ-024 SHALL, on step in RUN with rcon_idx < N-1, update rcon and increment rcon_idx.
REQ-025 SHALL, on step in RUN with rcon_idx = N-1, enter IDLE, reload rcon to 0x01, clear rcon_idx, and pulse done next cycle.
REQ-026 SHALL drive last = busy AND (rcon_idx = N-1).
REQ-027 SHALL ignore step in IDLE and start in RUN, with no state change and no err.
REQ-028 SHALL give abort priority over step and start in any state: IDLE next cycle, rcon 0x01, rcon_idx 0, no done pulse.
REQ-029 SHALL use the constant sharing for sh_rcon: share 0 = rcon AND {8{mask_rcon AND busy}}, shares 1..d-1 = 0; bit b of share s at index d*b+s.
REQ-030 SHALL drive sh_rcon combinationally from registered rcon; busy, last, rcon_idx and sh_rcon change only on clock edges following the inputs.
REQ-031 SHALL never use randomness; the output sharing is deterministic.

Reset
REQ-032 SHALL, while rst is high, hold asynchronously: state IDLE, rcon 0x01, rcon_idx 0, busy 0, last 0, done 0, err 0, sh_rcon all zero.
REQ-033 SHALL, on rst mid-sequence, drop busy immediately with no done pulse; the first post-reset start behaves normally.

Verification
REQ-034 SHALL test: start, mode 00, fwd, mask 1, then 10 steps -> share0 sequence 01,02,04,08,10,20,40,80,1b,36; last on the 10th constant; done the cycle after the 10th step.
REQ-035 SHALL test: start, mode 01, inverse -> 80,40,20,10,08,04,02,01; rcon_idx 0..7; then IDLE.
REQ-036 SHALL test: start, mode 10, inverse, steps with mask toggling -> 40..01 when mask=1, all-zero sh_rcon when mask=0; rcon_idx still advances.
REQ-037 SHALL test: mode 11 start (and mode 01 with EN_192=0) -> err pulse, busy stays 0.
REQ-038 SHALL test: abort and step together at rcon_idx 4, then async rst mid-run -> IDLE, rcon 0x01, no done.
REQ-039 SHALL test: d=3, mode 00 fwd -> bits at indices 3b+1 and 3b+2 always 0; share 0 matches REQ-034.
